// File: rtl/par_to_ser.sv
// Byte-burst to serial framer: alternating preamble, then each buffered byte MSB-first.
// Define PAR_TO_SER_PARITY_EN to append an even-parity bit after every byte.
//
// state | meaning
// IDLE  | waiting for the first byte of a burst
// PRE   | sending the alternating preamble
// DATA  | shifting bytes out; holds with en_o=0 if the FIFO runs dry while the burst is open
// DONE  | one idle cycle with busy_o low before returning to IDLE
module par_to_ser #(
  parameter int PREAMBLE = 6,
  parameter int DEPTH    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] prl_data_i,
  output logic       ser_data_o,
  output logic       en_o,
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

`ifdef PAR_TO_SER_PARITY_EN
  localparam logic [3:0] FIRST_IDX = 4'd8;
`else
  localparam logic [3:0] FIRST_IDX = 4'd7;
`endif

  logic [1:0]    state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [5:0]    pre_cnt;
  logic          pre_bit;
  logic [7:0]    sh;
  logic [3:0]    bit_cnt;
  logic          loaded;
  logic          burst_open;
  logic          ignore;

  logic          empty, full, accept, push, pop, burst_live, last_bit, cur_bit;
  logic [7:0]    head;

  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head       = mem[rd_ptr[AW-1:0]];
    accept     = (state == IDLE) && en_i && !ignore;
    push       = en_i && (accept || burst_open) && !full;
    burst_live = burst_open && en_i;
    last_bit   = (bit_cnt == 4'd0);
    pop        = 1'b0;
    if (state == PRE && pre_cnt == 6'd0 && !empty)
      pop = 1'b1;
    else if (state == DATA && (!loaded || last_bit) && !empty)
      pop = 1'b1;
  end

`ifdef PAR_TO_SER_PARITY_EN
  logic [3:0] data_idx;
  always_comb begin
    data_idx = bit_cnt - 4'd1;
    cur_bit  = last_bit ? ^sh : sh[data_idx[2:0]];
  end
`else
  always_comb begin
    cur_bit = sh[bit_cnt[2:0]];
  end
`endif

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= prl_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pre_cnt    <= '0;
      pre_bit    <= 1'b0;
      sh         <= '0;
      bit_cnt    <= '0;
      loaded     <= 1'b0;
      burst_open <= 1'b0;
      ignore     <= 1'b0;
      ser_data_o <= 1'b0;
      en_o       <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      burst_open <= accept ? 1'b1 : burst_live;
      // A burst starting while busy is swallowed until en_i drops, even past DONE.
      if (!en_i)
        ignore <= 1'b0;
      else if (busy_o && !burst_open)
        ignore <= 1'b1;

      case (state)
        IDLE: begin
          en_o       <= 1'b0;
          ser_data_o <= 1'b0;
          if (accept) begin
            busy_o  <= 1'b1;
            pre_cnt <= 6'(PREAMBLE - 1);
            pre_bit <= 1'b1;
            state   <= PRE;
          end
        end
        PRE: begin
          en_o       <= 1'b1;
          ser_data_o <= pre_bit;
          pre_bit    <= ~pre_bit;
          if (pre_cnt == 6'd0) begin
            sh      <= head;
            bit_cnt <= FIRST_IDX;
            loaded  <= 1'b1;
            state   <= DATA;
          end else begin
            pre_cnt <= pre_cnt - 6'd1;
          end
        end
        DATA: begin
          if (loaded) begin
            en_o       <= 1'b1;
            ser_data_o <= cur_bit;
            if (!last_bit) begin
              bit_cnt <= bit_cnt - 4'd1;
            end else if (!empty) begin
              sh      <= head;
              bit_cnt <= FIRST_IDX;
            end else begin
              loaded <= 1'b0;
              if (!burst_live) state <= DONE;
            end
          end else begin
            en_o       <= 1'b0;
            ser_data_o <= 1'b0;
            if (!empty) begin
              sh      <= head;
              bit_cnt <= FIRST_IDX;
              loaded  <= 1'b1;
            end else if (!burst_live) begin
              state <= DONE;
            end
          end
        end
        default: begin
          en_o       <= 1'b0;
          ser_data_o <= 1'b0;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_to_ser.sv
// Scoreboard bench for par_to_ser: expected line bits are queued as bursts are driven
// and compared bit by bit while en_o is high.
module tb_par_to_ser;

  localparam int PREAMBLE = 6;
  localparam int DEPTH    = 8;
`ifdef PAR_TO_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b0;
  logic [7:0] prl_data_i = 8'h00;
  logic       ser_data_o, en_o, busy_o;

  par_to_ser #(.PREAMBLE(PREAMBLE), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .prl_data_i(prl_data_i),
    .ser_data_o(ser_data_o), .en_o(en_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  logic       exp_q[$];
  logic [7:0] stim[$];
  int         run_len = 0;
  int         last_run = 0;
  int         frames = 0;
  logic       busy_at_fall = 1'b1;
  logic       mon_exp;
  int         f0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue the preamble plus the first n_acc bytes of stim, then drive all of stim.
  task automatic burst(input int n_acc);
    logic [7:0] v;
    for (int i = 0; i < PREAMBLE; i++) exp_q.push_back(i % 2 == 0);
    for (int i = 0; i < n_acc; i++) begin
      v = stim[i];
      for (int b = 7; b >= 0; b--) exp_q.push_back(v[b]);
`ifdef PAR_TO_SER_PARITY_EN
      exp_q.push_back(^v);
`endif
    end
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk_i);
      en_i = 1'b1;
      prl_data_i = stim[i];
    end
    @(negedge clk_i);
    en_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_len);
    int n = 0;
    while ((busy_o || en_o || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_done"}, n < 2000, 1);
    @(negedge clk_i);
    #1;
    chk({tag, "_len"}, last_run, exp_len);
    chk({tag, "_busy_fall"}, busy_at_fall, 0);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (en_o) begin
        run_len++;
        chk("busy_hi", busy_o, 1);
        if (exp_q.size() == 0) begin
          chk("extra_bit", en_o, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("ser_bit", ser_data_o, mon_exp);
        end
      end else begin
        chk("ser_idle", ser_data_o, 0);
        if (run_len != 0) begin
          last_run     = run_len;
          busy_at_fall = busy_o;
          frames++;
          run_len = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_ser", ser_data_o, 0);
    chk("rst_en", en_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    stim = '{8'hA9};
    burst(1);
    wait_idle("single", PREAMBLE + NB);

    stim = '{8'hBA, 8'hA2, 8'hE3, 8'hAA, 8'hBF};
    f0 = frames;
    burst(5);
    wait_idle("five", PREAMBLE + 5 * NB);
    chk("five_frames", frames - f0, 1);

    stim = '{8'hB9, 8'hB9};
    burst(2);
    wait_idle("hold2", PREAMBLE + 2 * NB);

    // A burst started mid-frame and held past the frame's end must be ignored entirely.
    stim = '{8'h3C};
    f0 = frames;
    burst(1);
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 20; i++) begin
      en_i = 1'b1;
      prl_data_i = 8'($urandom_range(255));
      @(negedge clk_i);
    end
    en_i = 1'b0;
    wait_idle("ignored", PREAMBLE + NB);
    repeat (20) @(negedge clk_i);
    chk("ignored_frames", frames - f0, 1);

    // One slot frees at the first pop (PREAMBLE < DEPTH), so DEPTH+1 bytes survive.
    stim.delete();
    for (int i = 0; i < DEPTH + 3; i++) stim.push_back(8'(8'h11 * i + 8'h05));
    burst(DEPTH + 1);
    wait_idle("overflow", PREAMBLE + (DEPTH + 1) * NB);

    stim = '{8'hC3};
    burst(1);
    repeat (8) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_ser", ser_data_o, 0);
    chk("arst_en", en_o, 0);
    chk("arst_busy", busy_o, 0);
    exp_q.delete();
    run_len = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("post_rst_en", en_o, 0);
    chk("post_rst_busy", busy_o, 0);
    f0 = frames;
    stim = '{8'h55};
    burst(1);
    wait_idle("fresh", PREAMBLE + NB);
    chk("fresh_frames", frames - f0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
